// File: rtl/piso_feeder.sv
// Parallel-in serial-out feeder: streams WIDTH-bit words MSB first with a valid/ready load side.
// Define PISO_FEEDER_HOLD_EN to add a one-word holding register for a gapless stream.
module piso_feeder #(
    parameter int WIDTH = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             en,
    output logic             x,
    output logic             x_valid,
    output logic             word_done
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             w_ready;
    logic             w_xfer;
    logic             w_last_adv;
    logic             w_load;
    logic [WIDTH-1:0] w_load_word;

`ifdef PISO_FEEDER_HOLD_EN
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;

    assign w_ready = ~r_hold_full;
`else
    assign w_ready = (r_state == IDLE);
`endif

    assign din_ready  = w_ready;
    assign w_xfer     = din_valid & w_ready;
    assign w_last_adv = (r_state == SHIFT) & en & (r_cnt == LAST_CNT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_load_word = din;
        x           = 1'b0;
        x_valid     = 1'b0;
        word_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end
            end
            SHIFT: begin
                x         = r_sreg[WIDTH-1];
                x_valid   = 1'b1;
                word_done = (r_cnt == LAST_CNT);
                if (w_last_adv) begin
`ifdef PISO_FEEDER_HOLD_EN
                    // Queued word takes priority; with an empty holder a same-edge transfer goes straight in.
                    if (r_hold_full) begin
                        w_load      = 1'b1;
                        w_load_word = r_hold;
                    end else if (w_xfer) begin
                        w_load = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
`else
                    w_next = IDLE;
`endif
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_sreg <= w_load_word;
            r_cnt  <= '0;
        end else if (w_last_adv) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if ((r_state == SHIFT) && en) begin
            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + 1'b1;
        end
    end

`ifdef PISO_FEEDER_HOLD_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_xfer && (r_state == SHIFT) && !w_last_adv) begin
            r_hold      <= din;
            r_hold_full <= 1'b1;
        end else if (w_last_adv && r_hold_full) begin
            r_hold_full <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_piso_feeder.sv
// Scoreboard bench for piso_feeder: directed scenarios plus randomized valid/en/reset traffic.
// The reference model is an expected-bit queue; build with PISO_FEEDER_HOLD_EN to match the RTL option.
module tb_piso_feeder;

    localparam int W = 12;
`ifdef PISO_FEEDER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         en;
    logic         x;
    logic         x_valid;
    logic         word_done;

    always #5 CLK = ~CLK;

    piso_feeder #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .en        (en),
        .x         (x),
        .x_valid   (x_valid),
        .word_done (word_done)
    );

    // Each entry is {bit, last_bit_of_word}; head is the bit that should be on x right now.
    logic [1:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_en   = 1'b0;
    bit         accepted = 1'b0;
    logic       rdy_model = 1'b1;
    logic       exp_vld;
    logic [1:0] head;

    // Without holding register: only empty pipeline accepts. With it: room while at most one word is queued.
    function automatic logic model_ready(int depth);
        if (HOLD) return (depth <= W);
        return (depth == 0);
    endfunction

    task automatic check(input string name, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    // Stimulus side of the scoreboard: a transfer pushes the word's bits, reset flushes.
    always @(posedge CLK) begin
        accepted = 1'b0;
        if (RST === 1'b1) begin
            exp_q.delete();
        end else if (din_valid === 1'b1 && rdy_model === 1'b1) begin
            accepted = 1'b1;
            for (int i = W - 1; i >= 0; i--) begin
                exp_q.push_back({din[i], (i == 0) ? 1'b1 : 1'b0});
            end
        end
    end

    // Monitor: compare presented outputs, then consume the head bit if the coming edge advances.
    always @(negedge CLK) begin
        exp_vld   = (exp_q.size() != 0);
        rdy_model = model_ready(exp_q.size());
        if (mon_en) begin
            check("din_ready", din_ready, rdy_model);
            check("x_valid", x_valid, exp_vld);
            if (exp_vld) begin
                head = exp_q[0];
                check("x_bit", x, head[1]);
                check("word_done", word_done, head[0]);
            end else begin
                check("x_idle", x, 1'b0);
                check("word_done_idle", word_done, 1'b0);
            end
        end
        if (exp_vld && en === 1'b1) void'(exp_q.pop_front());
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic offer(input logic [W-1:0] w);
        din       = w;
        din_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            cyc(1);
            if (accepted) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL offer_timeout: word %h not accepted within 200 cycles", w);
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (exp_q.size() == 0) begin
                cyc(1);
                return;
            end
            cyc(1);
        end
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: %0d bits still pending", exp_q.size());
    endtask

    initial begin
        RST       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        en        = 1'b1;
        cyc(2);
        mon_en = 1'b1;
        cyc(1);
        RST = 1'b0;
        cyc(1);

        // Single word, continuous enable
        offer(12'hA93);
        din_valid = 1'b0;
        drain();
        cyc(2);

        // Two words offered back to back
        offer(12'hA93);
        offer(12'hFFF);
        din_valid = 1'b0;
        drain();
        cyc(2);

        // Three words offered continuously
        offer(12'hA93);
        offer(12'h555);
        offer(12'h0F0);
        din_valid = 1'b0;
        drain();
        cyc(2);

        // Stall for three edges while bit index 5 is presented
        offer(12'hA93);
        din_valid = 1'b0;
        cyc(5);
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        drain();
        cyc(2);

        // Accept in idle with en low; first bit must hold
        en = 1'b0;
        offer(12'h5A5);
        din_valid = 1'b0;
        cyc(3);
        en = 1'b1;
        drain();
        cyc(2);

        // Reset during bit 7, then a new word restarts at its MSB
        offer(12'hA93);
        din_valid = 1'b0;
        cyc(7);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        cyc(1);
        // A word offered during reset must be ignored
        RST       = 1'b1;
        din       = 12'hFFF;
        din_valid = 1'b1;
        cyc(1);
        RST       = 1'b0;
        din_valid = 1'b0;
        cyc(1);
        offer(12'h0C3);
        din_valid = 1'b0;
        drain();
        cyc(2);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            RST       = ($urandom_range(0, 249) == 0);
            din_valid = ($urandom_range(0, 3) != 0);
            din       = W'($urandom);
            en        = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        RST       = 1'b0;
        din_valid = 1'b0;
        en        = 1'b1;
        drain();
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
